// File: rtl/multi_link.sv
// Board-to-board status link: sends the local multiplayer status byte every
// TX_PERIOD cycles as an 8N1 frame and validates the opponent's frames.
module multi_link #(
  parameter int unsigned CLKS_PER_BIT   = 564,
  parameter int unsigned TX_PERIOD      = 65000,
  parameter int unsigned TIMEOUT_CYCLES = 650000
) (
  input  logic pclk,
  input  logic rst,
  input  logic player_ready,
  input  logic multiplayer,
  input  logic game_over,
  input  logic victory,
  input  logic rx_in,
  output logic tx_out,
  output logic opponent_ready,
  output logic opponent_multi,
  output logic opponent_game_over,
  output logic opponent_victory,
  output logic link_up,
  output logic frame_err
);

  localparam int unsigned PER_W    = $clog2(TX_PERIOD);
  localparam int unsigned BIT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [3:0]  TAG      = 4'hA;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Transmit path
  logic [PER_W-1:0] per_q, per_d;
  tx_state_t        tx_state_q, tx_state_d;
  logic [BIT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_out_q, tx_out_d;

  // Receive path
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             rx_prev_q, rx_prev_d;
  rx_state_t        rx_state_q, rx_state_d;
  logic [BIT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [3:0]       opp_q, opp_d;
  logic             link_q, link_d;
  logic             err_q, err_d;
  logic [TO_W-1:0]  to_q, to_d;

  logic tx_bit_end;
  logic rx_bit_end;
  logic rx_done;
  logic rx_ok;

  // Frame scheduler and serializer; status is latched only at period start
  always_comb begin
    per_d      = (per_q == PER_W'(TX_PERIOD - 1)) ? '0 : per_q + 1'b1;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    tx_bit_end = (tx_cnt_q == BIT_W'(CLKS_PER_BIT - 1));

    case (tx_state_q)
      TX_IDLE: begin
        tx_out_d = 1'b1;
        if (per_q == '0) begin
          tx_shift_d = {TAG, victory, game_over, multiplayer, player_ready};
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_out_d   = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_out_d   = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_out_d   = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_out_d   = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        tx_out_d = 1'b1;
        if (tx_bit_end) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_out_d   = 1'b1;
      end
    endcase
  end

  // Synchronized receiver, frame validation and link timeout
  always_comb begin
    sync1_d    = rx_in;
    sync2_d    = sync1_q;
    rx_prev_d  = sync2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    opp_d      = opp_q;
    link_d     = link_q;
    err_d      = 1'b0;
    to_d       = (to_q == TO_W'(TIMEOUT_CYCLES)) ? to_q : to_q + 1'b1;
    rx_bit_end = (rx_cnt_q == BIT_W'(CLKS_PER_BIT - 1));
    rx_done    = 1'b0;
    rx_ok      = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        // Only a 1->0 transition starts a frame, so a stuck-low line cannot retrigger
        if (rx_prev_q && !sync2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == BIT_W'(HALF_BIT - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
          rx_done    = 1'b1;
          rx_ok      = sync2_q && (rx_shift_q[7:4] == TAG);
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    if (to_d == TO_W'(TIMEOUT_CYCLES)) begin
      link_d = 1'b0;
      opp_d  = '0;
    end

    // A valid frame overrides a timeout landing on the same edge
    if (rx_done) begin
      if (rx_ok) begin
        opp_d  = rx_shift_q[3:0];
        link_d = 1'b1;
        to_d   = '0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      per_q      <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_out_q   <= 1'b1;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      opp_q      <= '0;
      link_q     <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= '0;
    end else begin
      per_q      <= per_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_out_q   <= tx_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      opp_q      <= opp_d;
      link_q     <= link_d;
      err_q      <= err_d;
      to_q       <= to_d;
    end
  end

  assign tx_out             = tx_out_q;
  assign opponent_ready     = opp_q[0];
  assign opponent_multi     = opp_q[1];
  assign opponent_game_over = opp_q[2];
  assign opponent_victory   = opp_q[3];
  assign link_up            = link_q;
  assign frame_err          = err_q;

endmodule

// File: tb/tb_multi_link.sv
// Bench for multi_link: line-level model of the link checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_multi_link;
  localparam int CPB    = 8;
  localparam int PERIOD = 200;
  localparam int TMO    = 1000;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  logic player_ready = 1'b0, multiplayer = 1'b0, game_over = 1'b0, victory = 1'b0;
  logic loop_en = 1'b1;
  logic inj     = 1'b1;
  logic rx_in;
  logic tx_out, opponent_ready, opponent_multi, opponent_game_over, opponent_victory;
  logic link_up, frame_err;
  logic [3:0] opp_vec;

  assign rx_in   = loop_en ? tx_out : inj;
  assign opp_vec = {opponent_victory, opponent_game_over, opponent_multi, opponent_ready};

  always #5 pclk = ~pclk;

  multi_link #(.CLKS_PER_BIT(CPB), .TX_PERIOD(PERIOD), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .rst(rst),
    .player_ready(player_ready), .multiplayer(multiplayer),
    .game_over(game_over), .victory(victory),
    .rx_in(rx_in), .tx_out(tx_out),
    .opponent_ready(opponent_ready), .opponent_multi(opponent_multi),
    .opponent_game_over(opponent_game_over), .opponent_victory(opponent_victory),
    .link_up(link_up), .frame_err(frame_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic rx_s = 1'b1, pr_s = 1'b0, mp_s = 1'b0, go_s = 1'b0, vi_s = 1'b0;
  logic hist [0:4095];
  int   n_edge  = -1;
  int   fs      = -1;
  int   next_ok = 0;
  int   pend_at = -1;
  int   tcount  = 0;
  int   k;
  logic       pend_ok;
  logic [7:0] pend_data, m_byte, b;
  logic [3:0] m_opp  = 4'h0;
  logic       m_link = 1'b0, m_err = 1'b0, m_tx = 1'b1;

  function automatic logic rv(input int i);
    return (i < 0) ? 1'b1 : hist[12'(i)];
  endfunction

  // Line value and inputs as the DUT will capture them on the next rising edge
  always @(negedge pclk) begin
    rx_s = rx_in;
    pr_s = player_ready; mp_s = multiplayer; go_s = game_over; vi_s = victory;
  end

  always @(posedge pclk) begin
    if (rst) begin
      n_edge = -1; fs = -1; next_ok = 0; pend_at = -1; tcount = 0;
      m_opp = 4'h0; m_link = 1'b0; m_err = 1'b0; m_tx = 1'b1;
    end else begin
      n_edge++;
      hist[12'(n_edge)] = rx_s;
      // transmitter: frame every PERIOD edges starting with the first edge after reset
      k = n_edge % PERIOD;
      if (k == 0) m_byte = {4'hA, vi_s, go_s, mp_s, pr_s};
      if (k < CPB) m_tx = 1'b0;
      else if (k < 9 * CPB) m_tx = m_byte[3'(k / CPB - 1)];
      else m_tx = 1'b1;
      // receiver: frame anchored at the first sampled low after a high
      if (fs < 0) begin
        if (n_edge >= next_ok && rx_s == 1'b0 && rv(n_edge - 1) == 1'b1) fs = n_edge;
      end else if (n_edge == fs + CPB / 2 && rx_s == 1'b1) begin
        fs = -1; next_ok = n_edge + 1;
      end else if (n_edge == fs + 9 * CPB + CPB / 2) begin
        for (int i = 0; i < 8; i++) b[i] = hist[12'(fs + CPB / 2 + CPB * (i + 1))];
        pend_data = b;
        pend_ok   = rx_s && (b[7:4] == 4'hA);
        pend_at   = n_edge + 2;
        fs = -1; next_ok = n_edge + 1;
      end
      m_err = 1'b0;
      if (pend_at == n_edge && pend_ok) begin
        m_opp = pend_data[3:0]; m_link = 1'b1; tcount = 0;
      end else begin
        if (tcount < TMO) tcount++;
        if (tcount == TMO) begin m_opp = 4'h0; m_link = 1'b0; end
        if (pend_at == n_edge) m_err = 1'b1;
      end
      if (pend_at == n_edge) pend_at = -1;
    end
  end

  // Every-cycle comparison against the model, plus a frame_err pulse monitor
  int err_cnt  = 0;
  int err_edge = -1;
  always @(posedge pclk) begin
    #1;
    chk("tx_out", 32'(tx_out), 32'(m_tx));
    chk("opponent", 32'(opp_vec), 32'(m_opp));
    chk("link_up", 32'(link_up), 32'(m_link));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    if (frame_err) begin err_cnt++; err_edge = n_edge; end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_to(input int e);
    int g;
    g = 0;
    while (n_edge < e && g < 4000) begin
      @(posedge pclk); #1; g++;
    end
    if (n_edge < e) begin
      errors++; checks++;
      $display("FAIL wait_to: edge %0d never reached (at %0d)", e, n_edge);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    logic [9:0] f;
    f = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      inj = f[i];
      repeat (CPB) @(posedge pclk);
      #1;
    end
    inj = 1'b1;
  endtask

  logic [9:0] seq_a1;
  int e0;

  initial begin
    seq_a1 = {1'b1, 8'hA1, 1'b0};
    player_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_tx", 32'(tx_out), 32'd1);
    chk("rst_opp", 32'(opp_vec), 32'd0);
    chk("rst_link", 32'(link_up), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    #1 rst = 1'b0;

    // 1: loopback, byte A1 on the wire mid-bit, received 79 edges after first frame start
    for (int i = 0; i < 10; i++) begin
      wait_to(CPB / 2 + CPB * i);
      chk("t1_wire_bit", 32'(tx_out), 32'(seq_a1[i]));
    end
    wait_to(78);
    chk("t1_link_before", 32'(link_up), 32'd0);
    wait_to(79);
    chk("t1_ready", 32'(opponent_ready), 32'd1);
    chk("t1_link", 32'(link_up), 32'd1);
    chk("t1_err", 32'(frame_err), 32'd0);

    // 2: change status mid-frame; next frame still A1, the one after carries A4
    wait_to(220);
    player_ready = 1'b0; game_over = 1'b1;
    wait_to(280);
    chk("t2_old_byte", 32'(opp_vec), 32'h1);
    wait_to(480);
    chk("t2_new_byte", 32'(opp_vec), 32'h4);
    loop_en = 1'b0;

    // 3: wrong tag 0x51 rejected with a single-cycle pulse
    wait_to(500);
    e0 = err_cnt;
    send_frame(8'h51, 1'b1);
    wait_to(590);
    chk("t3_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("t3_err_edge", 32'(err_edge), 32'd579);
    chk("t3_opp_kept", 32'(opp_vec), 32'h4);

    // 4: bad stop bit, then a 2-cycle glitch, then a valid A8 frame
    wait_to(600);
    e0 = err_cnt;
    send_frame(8'hA5, 1'b0);
    wait_to(690);
    chk("t4_stop_err", 32'(err_cnt - e0), 32'd1);
    chk("t4_err_edge", 32'(err_edge), 32'd679);
    wait_to(700);
    e0 = err_cnt;
    inj = 1'b0;
    wait_to(702);
    inj = 1'b1;
    wait_to(720);
    chk("t4_glitch_err", 32'(err_cnt - e0), 32'd0);
    send_frame(8'hA8, 1'b1);
    chk("t4_after_glitch", 32'(opp_vec), 32'h8);
    chk("t4_after_glitch_link", 32'(link_up), 32'd1);

    // 5: timeout exactly TMO edges after the update at edge 799
    wait_to(1798);
    chk("t5_link_hold", 32'(link_up), 32'd1);
    wait_to(1799);
    chk("t5_link_drop", 32'(link_up), 32'd0);
    chk("t5_opp_drop", 32'(opp_vec), 32'h0);

    // broken wire: one error pulse, no retrigger while held low
    wait_to(1900);
    e0 = err_cnt;
    inj = 1'b0;
    wait_to(2200);
    inj = 1'b1;
    chk("stuck_pulses", 32'(err_cnt - e0), 32'd1);
    chk("stuck_edge", 32'(err_edge), 32'd1979);

    // 6: reset in the middle of a frame, then restart
    wait_to(2250);
    player_ready = 1'b1; multiplayer = 1'b1; game_over = 1'b0;
    wait_to(2300);
    loop_en = 1'b1;
    wait_to(2480);
    chk("t6_pre_opp", 32'(opp_vec), 32'h3);
    wait_to(2630);
    chk("t6_pre_tx_low", 32'(tx_out), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_tx", 32'(tx_out), 32'd1);
    chk("t6_async_opp", 32'(opp_vec), 32'h0);
    chk("t6_async_link", 32'(link_up), 32'd0);
    chk("t6_async_err", 32'(frame_err), 32'd0);
    repeat (3) @(posedge pclk);
    #2 rst = 1'b0;
    wait_to(0);
    chk("t6_restart_tx", 32'(tx_out), 32'd0);
    wait_to(78);
    chk("t6_no_stale_opp", 32'(opp_vec), 32'h0);
    chk("t6_no_stale_link", 32'(link_up), 32'd0);
    wait_to(79);
    chk("t6_new_opp", 32'(opp_vec), 32'h3);
    chk("t6_new_link", 32'(link_up), 32'd1);

    wait_to(90);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
